// File: rtl/DebugTypes.sv
// rtl/DebugTypes.sv - shared trace types; DEBUG_TRACE_TIMESTAMP_EN adds the timestamp field.
package DebugTypes;

  localparam int TRACE_TS_WIDTH   = 32;
  localparam int TRACE_PC_WIDTH   = 32;
  localparam int TRACE_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2
  } TraceState;

  // Layout at the default widths; the top rebuilds it from its own parameters.
  typedef struct packed {
`ifdef DEBUG_TRACE_TIMESTAMP_EN
    logic [TRACE_TS_WIDTH-1:0]   timestamp;
`endif
    logic [TRACE_PC_WIDTH-1:0]   pc;
    logic [4:0]                  rd;
    logic                        we;
    logic [TRACE_DATA_WIDTH-1:0] data;
  } TraceEntry;

endpackage

// File: rtl/debug_trace_fifo.sv
// rtl/debug_trace_fifo.sv - circular FIFO; head entry read straight from storage flops.
module debug_trace_fifo #(
  parameter int  DEPTH = 16,
  parameter type T     = logic [7:0],
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  T              pushData,
  output logic          full,
  input  logic          pop,
  output T              popData,
  output logic          popValid,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  T              mem_q [DEPTH];
  T              mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full     = (count_q == FULL_CNT);
  assign popValid = (count_q != '0);
  assign popData  = mem_q[rd_ptr_q];
  assign count    = count_q;

  always_comb begin
    do_pop   = pop && popValid;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = pushData;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/debug_trace_buffer.sv
// rtl/debug_trace_buffer.sv - armed/triggered commit trace capture with streamed readout.
// DEBUG_TRACE_TIMESTAMP_EN prepends a 32-bit cycle timestamp to every entry.
module debug_trace_buffer
  import DebugTypes::*;
#(
  parameter int  DEPTH      = 16,
  parameter int  PC_WIDTH   = 32,
  parameter int  DATA_WIDTH = 32,
  parameter int  OVF_WIDTH  = 16,
`ifdef DEBUG_TRACE_TIMESTAMP_EN
  localparam int ENTRY_W    = TRACE_TS_WIDTH + PC_WIDTH + 6 + DATA_WIDTH,
`else
  localparam int ENTRY_W    = PC_WIDTH + 6 + DATA_WIDTH,
`endif
  localparam int CW         = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  commitValid,
  input  logic [PC_WIDTH-1:0]   commitPC,
  input  logic [4:0]            commitRd,
  input  logic                  commitWe,
  input  logic [DATA_WIDTH-1:0] commitData,
  input  logic                  armReq,
  input  logic                  stopReq,
  input  logic                  triggerEn,
  input  logic [PC_WIDTH-1:0]   triggerPC,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [ENTRY_W-1:0]    outEntry,
  output logic [1:0]            traceState,
  output logic [CW-1:0]         entryCount,
  output logic [OVF_WIDTH-1:0]  overflowCount
);

  typedef struct packed {
`ifdef DEBUG_TRACE_TIMESTAMP_EN
    logic [TRACE_TS_WIDTH-1:0] timestamp;
`endif
    logic [PC_WIDTH-1:0]       pc;
    logic [4:0]                rd;
    logic                      we;
    logic [DATA_WIDTH-1:0]     data;
  } entry_t;

  TraceState            state_q, state_d;
  logic [OVF_WIDTH-1:0] ovf_q, ovf_d;
  logic                 trig_match, push_req, pop, fifo_full, drop;
  entry_t               push_entry, pop_entry;

`ifdef DEBUG_TRACE_TIMESTAMP_EN
  logic [TRACE_TS_WIDTH-1:0] ts_q, ts_d;

  assign ts_d = ts_q + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_d;
    end
  end
`endif

  assign pop           = outValid && outReady;
  assign traceState    = state_q;
  assign overflowCount = ovf_q;
  assign outEntry      = pop_entry;

  always_comb begin
`ifdef DEBUG_TRACE_TIMESTAMP_EN
    push_entry.timestamp = ts_q;
`endif
    push_entry.pc   = commitPC;
    push_entry.rd   = commitRd;
    push_entry.we   = commitWe;
    push_entry.data = commitData;
  end

  always_comb begin
    trig_match = commitValid && (!triggerEn || (commitPC == triggerPC));
    state_d    = state_q;
    ovf_d      = ovf_q;
    push_req   = 1'b0;
    case (state_q)
      IDLE: begin
        if (armReq) begin
          state_d = ARMED;
          ovf_d   = '0;
        end
      end
      ARMED: begin
        // stop beats a coincident trigger: nothing of that cycle is recorded
        if (stopReq) begin
          state_d = IDLE;
        end else if (trig_match) begin
          state_d  = CAPTURE;
          push_req = 1'b1;
        end
      end
      CAPTURE: begin
        push_req = commitValid;
        if (stopReq) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    drop = push_req && fifo_full && !pop;
    if (drop && (ovf_q != '1)) begin
      ovf_d = ovf_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
    end
  end

  debug_trace_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst),
    .push     (push_req),
    .pushData (push_entry),
    .full     (fifo_full),
    .pop      (pop),
    .popData  (pop_entry),
    .popValid (outValid),
    .count    (entryCount)
  );

endmodule
